ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Prefetch buffer between a handshaked instruction memory and the IF/ID pipeline register of the five-stage MIPS core.
- Runs a sequential fetch PC, issues at most one outstanding memory request, and stores returned words with their PC+4 in a small FIFO.
- Presents the FIFO head to the decode stage, honours decode stalls, and flushes on branch/jump redirect from the MEM stage.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
RESET_PC, 32'd0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
redirect  in  1  branch/jump taken (pcsrc | jump_s4); flush and refetch
redirect_pc  in  32  new fetch address when redirect=1
hold  in  1  decode stall (stall_s1_s2); head is not consumed
mem_req  out  1  memory request, held until acknowledged
mem_addr  out  32  word address of the request, stable while mem_req=1
mem_ack  in  1  request complete this cycle; mem_rdata valid
mem_rdata  in  32  instruction word
inst_valid  out  1  FIFO head valid
inst  out  32  head instruction; 32'd0 when empty
inst_pc4  out  32  head PC+4
count  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, FIFO pointers and count=0, state=IDLE, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc4=0.
- All other state changes on the rising clk edge only.
- Space check: space = (count < DEPTH), evaluated after any same-cycle pop. At most one request is outstanding, so a request is issued only when space exists.
- FSM states:
  - IDLE: mem_req=0. If no redirect and space, go to WAIT with mem_req=1, mem_addr=fetch_pc.
  - WAIT: mem_req=1.
    - mem_ack and no redirect: push {mem_rdata, mem_addr+4} and set fetch_pc=mem_addr+4. If a slot remains after this push and pop, issue the next request back-to-back (mem_req stays 1, mem_addr=new fetch_pc). Otherwise go to IDLE.
    - redirect and no ack: go to DROP. mem_req and mem_addr stay unchanged; the transaction cannot be abandoned.
    - redirect and ack in the same cycle: discard the data, set fetch_pc=redirect_pc, issue a request to redirect_pc next cycle.
  - DROP: mem_req=1 at the old address. On ack, discard the data and issue the request at fetch_pc (the redirect target), going to WAIT. A further redirect in DROP only updates fetch_pc.
- Redirect priority: redirect beats push, pop and hold. On redirect, count goes to 0, pointers reset, and fetch_pc=redirect_pc. inst_valid=0 the cycle after.
- Pop: occurs when inst_valid=1, hold=0 and redirect=0. Push and pop in the same cycle leave count unchanged.
- Outputs: inst_valid=(count!=0). inst and inst_pc4 come from the head entry, combinational from storage, and are zero when empty.
- Arithmetic: PC increments by 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000). Pointers wrap modulo DEPTH.
- Latency: with ack on the first WAIT cycle, the first instruction is valid 2 edges after reset release. With a single-cycle-ack memory and hold=0, throughput is one instruction per cycle.
- Reset mid-transaction: the outstanding request is dropped immediately (mem_req=0). The memory model must tolerate this.

Test Plan:
- Reset release, memory acks every cycle, words 0x20080005.. at 0,4,8: inst_valid rises on the 2nd edge, inst=0x20080005 with inst_pc4=0x4, then 0x8, 0xC; one instruction per cycle with hold=0.
- hold=1 throughout, ack every cycle: count saturates at 4, mem_req drops to 0 with mem_addr=0x10 pending. Release hold: 4 pops in order, then fetching resumes at 0x10.
- 3-cycle ack latency, redirect to 0x40 asserted in WAIT before ack: FIFO empties, mem_req stays high at the old address until ack, that data is discarded, next request is to 0x40, and the first inst_pc4 after that is 0x44.
- Redirect to 0x80 in the same cycle as an ack: the acked word is not pushed, count=0, the next mem_addr is 0x80.
- RESET_PC=0xFFFFFFF8, ack every cycle: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; inst_pc4 of the second entry is 0x00000000.
- Async reset pulsed mid-WAIT between clock edges: mem_req, inst_valid and count go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : Sequential instruction prefetcher; one outstanding memory request,
//            returned words queued with their PC+4 for the decode stage.
// Revision : 1.0
// ============================================================================
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   hold,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic                   inst_valid,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc4,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_mem_req;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_fetch_pc;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [31:0]         r_inst_mem [DEPTH];
    logic [31:0]         r_pc4_mem  [DEPTH];

    logic                w_pop;
    logic                w_push;
    logic                w_space;
    logic [c_cnt_w-1:0]  w_count_next;
    logic [31:0]         w_addr_inc;

    assign w_addr_inc = r_mem_addr + 32'd4;

    // Redirect outranks everything: the acked word and any pop are both dropped.
    assign w_pop  = (r_count != '0) && !hold && !redirect;
    assign w_push = (r_state == S_WAIT) && mem_ack && !redirect;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_cnt_one;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_cnt_one;
        end
    end

    // Only one request is ever in flight, so a free slot after this cycle's
    // push/pop is enough to launch the next fetch.
    assign w_space = (w_count_next < c_depth);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= mem_rdata;
            r_pc4_mem[r_wr_ptr]  <= w_addr_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end else if (w_space) begin
                        r_state    <= S_WAIT;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                        if (mem_ack) begin
                            r_mem_addr <= redirect_pc;
                        end else begin
                            // The bus cannot abandon a request; ride it out in DROP.
                            r_state <= S_DROP;
                        end
                    end else if (mem_ack) begin
                        r_fetch_pc <= w_addr_inc;
                        r_mem_addr <= w_addr_inc;
                        if (!w_space) begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        r_state    <= S_WAIT;
                        r_mem_addr <= redirect ? redirect_pc : r_fetch_pc;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign count      = r_count;
    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_inst_mem[r_rd_ptr] : 32'd0;
    assign inst_pc4   = inst_valid ? r_pc4_mem[r_rd_ptr]  : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Purpose  : Scoreboard bench for ifetch_queue with a variable-latency memory.
// Revision : 1.0
// ============================================================================
module tb_ifetch_queue;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc4;
    } sb_entry_t;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc4;
    logic [2:0]  count;

    logic        wrap_req;
    logic [31:0] wrap_addr;
    logic        wrap_ack;
    logic [31:0] wrap_rdata;
    logic        wrap_valid;
    logic [31:0] wrap_inst;
    logic [31:0] wrap_pc4;
    logic [2:0]  wrap_count;
    logic        tie_zero;
    logic [31:0] tie_zero32;

    int          n_checks;
    int          n_fail;
    int          n_pops;
    int          mem_lat;
    int          wait_cnt;
    sb_entry_t   sb_q[$];
    bit          stale;
    logic [31:0] exp_fetch;
    bit          prev_req;
    bit          prev_ack;
    logic [31:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0005 + a;
    endfunction

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .hold(hold), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc4(inst_pc4), .count(count)
    );

    // Second instance checks PC wrap-around with an always-ready memory.
    assign tie_zero   = 1'b0;
    assign tie_zero32 = 32'd0;
    assign wrap_ack   = wrap_req;
    assign wrap_rdata = mem_word(wrap_addr);

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .redirect(tie_zero), .redirect_pc(tie_zero32),
        .hold(tie_zero), .mem_req(wrap_req), .mem_addr(wrap_addr), .mem_ack(wrap_ack),
        .mem_rdata(wrap_rdata), .inst_valid(wrap_valid), .inst(wrap_inst),
        .inst_pc4(wrap_pc4), .count(wrap_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog timeout");
    end

    // Memory model and scoreboard; both act on the falling edge so DUT outputs
    // and bench-driven inputs are settled.
    task automatic monitor();
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                wait_cnt  = 0;
                sb_q.delete();
                stale     = 1'b0;
                exp_fetch = 32'd0;
                prev_req  = 1'b0;
                prev_ack  = 1'b0;
                prev_addr = 32'd0;
            end else begin
                if (mem_req && wait_cnt >= mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'hDEAD_BEEF;
                    wait_cnt  = mem_req ? wait_cnt + 1 : 0;
                end

                if (mem_req && (!prev_req || prev_ack) && !stale) begin
                    n_checks++;
                    if (mem_addr !== exp_fetch) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h expected %h", mem_addr, exp_fetch);
                    end
                end
                if (mem_req && prev_req && !prev_ack) begin
                    n_checks++;
                    if (mem_addr !== prev_addr) begin
                        n_fail++;
                        $display("FAIL req_stable: got %h expected %h", mem_addr, prev_addr);
                    end
                end
                n_checks++;
                if (count !== 3'(sb_q.size())) begin
                    n_fail++;
                    $display("FAIL occupancy: got %0d expected %0d", count, sb_q.size());
                end
                if (!inst_valid) begin
                    n_checks++;
                    if (inst !== 32'd0 || inst_pc4 !== 32'd0) begin
                        n_fail++;
                        $display("FAIL empty_head: got %h/%h expected 0/0", inst, inst_pc4);
                    end
                end

                if (inst_valid && !hold && !redirect) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pop_underflow: got valid head %h expected empty", inst_pc4);
                    end else begin
                        e = sb_q.pop_front();
                        n_pops++;
                        if (inst !== e.data || inst_pc4 !== e.pc4) begin
                            n_fail++;
                            $display("FAIL pop_data: got %h/%h expected %h/%h",
                                     inst, inst_pc4, e.data, e.pc4);
                        end
                    end
                end

                if (redirect) begin
                    sb_q.delete();
                    stale     = mem_req && !mem_ack;
                    exp_fetch = redirect_pc;
                end else if (mem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        sb_q.push_back('{data: mem_word(mem_addr), pc4: mem_addr + 32'd4});
                        exp_fetch = mem_addr + 32'd4;
                    end
                end

                prev_req  = mem_req;
                prev_ack  = mem_ack;
                prev_addr = mem_addr;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset       = 1'b1;
        hold        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        n_checks++; if (mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", inst); end
        n_checks++; if (inst_pc4 !== 32'd0) begin n_fail++; $display("FAIL reset_pc4: got %h expected 0", inst_pc4); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (wrap_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_wrap_addr: got %h expected fffffff8", wrap_addr); end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        int base;
        mem_lat = 0;
        apply_reset();
        at_neg();
        at_neg();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL stream_first_req: got %b/%h expected 1/0", mem_req, mem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_edge1: got %b expected 0", inst_valid); end
        at_neg();
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid_edge2: got %b expected 1", inst_valid); end
        n_checks++; if (inst !== 32'h2008_0005 || inst_pc4 !== 32'h4) begin n_fail++; $display("FAIL stream_first_inst: got %h/%h expected 20080005/4", inst, inst_pc4); end
        for (int k = 0; k < 2; k++) begin
            at_neg();
            n_checks++;
            if (inst_pc4 !== 32'h8 + 32'(4 * k) || count !== 3'd1) begin
                n_fail++;
                $display("FAIL stream_seq%0d: got pc4 %h count %0d expected %h count 1", k, inst_pc4, count, 32'h8 + 32'(4 * k));
            end
        end
        base = n_pops;
        repeat (10) at_neg();
        n_checks++; if (n_pops - base != 10) begin n_fail++; $display("FAIL stream_throughput: got %0d pops expected 10", n_pops - base); end
    endtask

    task automatic test_hold();
        int base;
        mem_lat = 0;
        apply_reset();
        hold = 1'b1;
        repeat (8) at_neg();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL hold_count: got %0d expected 4", count); end
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL hold_pending: got %b/%h expected 0/10", mem_req, mem_addr); end
        n_checks++; if (inst !== mem_word(32'h0) || inst_pc4 !== 32'h4) begin n_fail++; $display("FAIL hold_head: got %h/%h expected 20080005/4", inst, inst_pc4); end
        tick();
        hold = 1'b0;
        base = n_pops;
        at_neg();
        at_neg();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL hold_resume: got %b/%h expected 1/10", mem_req, mem_addr); end
        repeat (6) at_neg();
        n_checks++; if (n_pops - base != 8) begin n_fail++; $display("FAIL hold_drain: got %0d pops expected 8", n_pops - base); end
    endtask

    task automatic test_redirect_wait();
        bit found;
        mem_lat = 3;
        apply_reset();
        hold  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (count == 3'd2) found = 1'b1;
        end
        n_checks++; if (!found || mem_addr !== 32'h8) begin n_fail++; $display("FAIL rw_fill: got found=%0d addr %h expected 1/8", found, mem_addr); end
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        hold     = 1'b0;
        at_neg();
        n_checks++; if (count !== 3'd0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rw_flush: got count %0d valid %b expected 0/0", count, inst_valid); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_fail++; $display("FAIL rw_drop_req: got %b/%h expected 1/8", mem_req, mem_addr); end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            at_neg();
            if (inst_valid === 1'b1) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rw_timeout: got no valid expected valid"); end
        n_checks++; if (inst_pc4 !== 32'h44 || inst !== mem_word(32'h40)) begin n_fail++; $display("FAIL rw_target: got %h/%h expected %h/44", inst, inst_pc4, mem_word(32'h40)); end
        repeat (8) at_neg();
    endtask

    task automatic test_redirect_ack();
        mem_lat = 0;
        apply_reset();
        hold = 1'b1;
        tick();
        tick();
        n_checks++; if (count !== 3'd1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL ra_pre: got count %0d req %b expected 1/1", count, mem_req); end
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        hold     = 1'b0;
        n_checks++; if (count !== 3'd0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL ra_flush: got count %0d valid %b expected 0/0", count, inst_valid); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin n_fail++; $display("FAIL ra_next_req: got %b/%h expected 1/80", mem_req, mem_addr); end
        at_neg();
        at_neg();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc4 !== 32'h84) begin n_fail++; $display("FAIL ra_first: got %b/%h expected 1/84", inst_valid, inst_pc4); end
        repeat (6) at_neg();
    endtask

    task automatic test_pc_wrap();
        mem_lat = 0;
        apply_reset();
        at_neg();
        at_neg();
        n_checks++; if (wrap_req !== 1'b1 || wrap_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_addr0: got %b/%h expected 1/fffffff8", wrap_req, wrap_addr); end
        at_neg();
        n_checks++; if (wrap_addr !== 32'hFFFF_FFFC || wrap_pc4 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr1: got %h/%h expected fffffffc/fffffffc", wrap_addr, wrap_pc4); end
        at_neg();
        n_checks++; if (wrap_addr !== 32'h0 || wrap_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_addr2: got %h/%h expected 0/0", wrap_addr, wrap_pc4); end
        n_checks++; if (wrap_inst !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_inst: got %h expected %h", wrap_inst, mem_word(32'hFFFF_FFFC)); end
    endtask

    task automatic test_async_reset();
        mem_lat = 0;
        apply_reset();
        hold = 1'b1;
        tick();
        tick();
        n_checks++; if (count !== 3'd1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got count %0d req %b expected 1/1", count, mem_req); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin n_fail++; $display("FAIL ar_req: got %b/%h expected 0/0", mem_req, mem_addr); end
        n_checks++; if (inst_valid !== 1'b0 || count !== 3'd0 || inst !== 32'd0) begin n_fail++; $display("FAIL ar_fifo: got valid %b count %0d inst %h expected 0/0/0", inst_valid, count, inst); end
        n_checks++; if (wrap_req !== 1'b0) begin n_fail++; $display("FAIL ar_wrap_req: got %b expected 0", wrap_req); end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        hold  = 1'b0;
        repeat (5) at_neg();
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL ar_restart: got %b expected 1", inst_valid); end
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        hold        = 1'b0;
        mem_lat     = 0;
        n_checks    = 0;
        n_fail      = 0;
        n_pops      = 0;
        fork
            monitor();
        join_none
        test_reset();
        test_streaming();
        test_hold();
        test_redirect_wait();
        test_redirect_ack();
        test_pc_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
